// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common data bus arbiter.
package cdb_arbiter_pkg;

  localparam int NUM_FU = 3;
  localparam int PREG_W = 6;
  localparam int ROB_W  = 5;
  localparam int DATA_W = 32;
  localparam int PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  localparam int FU_ALU = 0;
  localparam int FU_BR  = 1;
  localparam int FU_LSU = 2;

  typedef struct packed {
    logic [PREG_W-1:0] tag;
    logic [ROB_W-1:0]  rob_idx;
    logic [DATA_W-1:0] data;
    logic              br_mispred;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  // Walk the requesters starting at ptr, wrapping modulo N, and grant the first hit.
  always_comb begin
    logic             found;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(off);
      if (sum >= (PTR_W+1)'(N)) begin
        sum = sum - (PTR_W+1)'(N);
      end
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional unit, one broadcast per cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FU-1:0]     fu_valid,
  input  cdb_pkt_t [NUM_FU-1:0] fu_pkt,
  output logic [NUM_FU-1:0]     fu_ready,
  input  logic                  recovery_en,
  output logic                  cdb_en,
  output cdb_pkt_t              cdb_pkt,
  output logic [NUM_FU-1:0]     cdb_grant
);

  logic [NUM_FU-1:0]     slot_valid_q, slot_valid_d;
  cdb_pkt_t [NUM_FU-1:0] slot_pkt_q, slot_pkt_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_FU-1:0]     arb_gnt;

  rr_arbiter #(
    .N     (NUM_FU),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req (slot_valid_q),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt)
  );

  // Bus-side outputs depend only on held state and recovery, never on the incoming FU signals.
  always_comb begin
    cdb_grant = recovery_en ? '0 : arb_gnt;
    cdb_en    = (|slot_valid_q) & ~recovery_en;
    fu_ready  = {NUM_FU{~recovery_en}} & (~slot_valid_q | cdb_grant);
    cdb_pkt   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (cdb_grant[i]) begin
        cdb_pkt = cdb_pkt | slot_pkt_q[i];
      end
    end
  end

  // Slot fill/drain/flush and pointer advance past the granted slot.
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_pkt_d   = slot_pkt_q;
    rr_ptr_d     = rr_ptr_q;
    for (int i = 0; i < NUM_FU; i++) begin
      if (recovery_en) begin
        slot_valid_d[i] = 1'b0;
      end else if (fu_valid[i] && fu_ready[i]) begin
        slot_valid_d[i] = 1'b1;
        slot_pkt_d[i]   = fu_pkt[i];
      end else if (cdb_grant[i]) begin
        slot_valid_d[i] = 1'b0;
      end
      if (cdb_grant[i]) begin
        rr_ptr_d = (i == NUM_FU-1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  // State registers; reset drops every held result immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid_q <= '0;
      slot_pkt_q   <= '0;
      rr_ptr_q     <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_pkt_q   <= slot_pkt_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic                  clk;
  logic                  rst;
  logic [NUM_FU-1:0]     fu_valid;
  cdb_pkt_t [NUM_FU-1:0] fu_pkt;
  logic [NUM_FU-1:0]     fu_ready;
  logic                  recovery_en;
  logic                  cdb_en;
  cdb_pkt_t              cdb_pkt;
  logic [NUM_FU-1:0]     cdb_grant;

  int total = 0;
  int bad   = 0;

  cdb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .fu_valid    (fu_valid),
    .fu_pkt      (fu_pkt),
    .fu_ready    (fu_ready),
    .recovery_en (recovery_en),
    .cdb_en      (cdb_en),
    .cdb_pkt     (cdb_pkt),
    .cdb_grant   (cdb_grant)
  );

  // Free-running clock with a 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cdb_pkt_t mkPkt(input int tag, input int rob, input logic [31:0] data,
                                     input logic mis);
    cdb_pkt_t p;
    p.tag        = PREG_W'(tag);
    p.rob_idx    = ROB_W'(rob);
    p.data       = data;
    p.br_mispred = mis;
    return p;
  endfunction

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    fu_valid    = '0;
    fu_pkt      = '0;
    recovery_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst         = 1'b0;
    fu_valid    = '0;
    fu_pkt      = '0;
    recovery_en = 1'b0;
    #2;
    total++;
    if (cdb_en !== 1'b0 || cdb_grant !== 3'b000 || fu_ready !== 3'b111 || cdb_pkt !== '0) begin
      bad++;
      $display("[TB] FAIL reset_state got en=%0b gnt=%b rdy=%b pkt=%h want en=0 gnt=000 rdy=111 pkt=0",
               cdb_en, cdb_grant, fu_ready, cdb_pkt);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      nextCycle();
      total++;
      if (cdb_en !== 1'b0 || cdb_grant !== 3'b000 || fu_ready !== 3'b111) begin
        bad++;
        $display("[TB] FAIL idle_cycle%0d got en=%0b gnt=%b rdy=%b want en=0 gnt=000 rdy=111",
                 c, cdb_en, cdb_grant, fu_ready);
      end
    end
  endtask

  task automatic test_single;
    cdb_pkt_t exp;
    doReset();
    nextCycle();
    exp = mkPkt(5, 3, 32'hDEADBEEF, 1'b0);
    fu_valid = 3'b001;
    fu_pkt[FU_ALU] = exp;
    #1;
    total++;
    if (fu_ready !== 3'b111) begin
      bad++;
      $display("[TB] FAIL single_ready got=%b want=111", fu_ready);
    end
    nextCycle();
    fu_valid = '0;
    #1;
    total++;
    if (cdb_en !== 1'b1 || cdb_grant !== 3'b001 || cdb_pkt !== exp) begin
      bad++;
      $display("[TB] FAIL single_bcast got en=%0b gnt=%b pkt=%h want en=1 gnt=001 pkt=%h",
               cdb_en, cdb_grant, cdb_pkt, exp);
    end
    nextCycle();
    total++;
    if (cdb_en !== 1'b0 || cdb_pkt !== '0) begin
      bad++;
      $display("[TB] FAIL single_after got en=%0b pkt=%h want en=0 pkt=0", cdb_en, cdb_pkt);
    end
  endtask

  // Fill all three slots and expect grants in the given order.
  task automatic fillAllAndDrain(input string name, input logic [2:0] g0, input logic [2:0] g1,
                                 input logic [2:0] g2, input int base);
    cdb_pkt_t   p [3];
    logic [2:0] gexp [3];
    int         src;
    gexp[0] = g0; gexp[1] = g1; gexp[2] = g2;
    for (int i = 0; i < 3; i++) p[i] = mkPkt(base + i, base + i, 32'h1000 * (base + i + 1), i == 1);
    fu_valid = 3'b111;
    for (int i = 0; i < 3; i++) fu_pkt[i] = p[i];
    nextCycle();
    fu_valid = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      src = (gexp[k] == 3'b001) ? 0 : (gexp[k] == 3'b010) ? 1 : 2;
      total++;
      if (cdb_en !== 1'b1 || cdb_grant !== gexp[k] || cdb_pkt !== p[src]) begin
        bad++;
        $display("[TB] FAIL %s_grant%0d got en=%0b gnt=%b pkt=%h want en=1 gnt=%b pkt=%h",
                 name, k, cdb_en, cdb_grant, cdb_pkt, gexp[k], p[src]);
      end
      nextCycle();
    end
    #1;
    total++;
    if (cdb_en !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_drained got en=%0b want en=0", name, cdb_en);
    end
  endtask

  task automatic test_contention;
    doReset();
    nextCycle();
    fillAllAndDrain("contend", 3'b001, 3'b010, 3'b100, 10);
    // Pointer wrapped back to 0 after the loadstore grant.
    fillAllAndDrain("wrap", 3'b001, 3'b010, 3'b100, 20);
  endtask

  task automatic test_rotation;
    doReset();
    nextCycle();
    fu_valid = 3'b001;
    fu_pkt[FU_ALU] = mkPkt(1, 1, 32'h11, 1'b0);
    nextCycle();
    fu_valid = '0;
    nextCycle();
    // Pointer now sits at the branch slot.
    fillAllAndDrain("rotate", 3'b010, 3'b100, 3'b001, 30);
  endtask

  task automatic test_back_to_back;
    cdb_pkt_t exp;
    doReset();
    nextCycle();
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        fu_valid = 3'b001;
        fu_pkt[FU_ALU] = mkPkt(k, k, 32'd100 + 32'(k), 1'b0);
      end else begin
        fu_valid = '0;
      end
      #1;
      total++;
      if (fu_ready[0] !== 1'b1) begin
        bad++;
        $display("[TB] FAIL stream_ready%0d got=%0b want=1", k, fu_ready[0]);
      end
      if (k > 0) begin
        exp = mkPkt(k - 1, k - 1, 32'd100 + 32'(k - 1), 1'b0);
        total++;
        if (cdb_en !== 1'b1 || cdb_grant !== 3'b001 || cdb_pkt !== exp) begin
          bad++;
          $display("[TB] FAIL stream_bcast%0d got en=%0b gnt=%b pkt=%h want en=1 gnt=001 pkt=%h",
                   k, cdb_en, cdb_grant, cdb_pkt, exp);
        end
      end
      nextCycle();
    end
    total++;
    if (cdb_en !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stream_end got en=%0b want en=0", cdb_en);
    end
  endtask

  task automatic test_recovery;
    doReset();
    nextCycle();
    fu_valid = 3'b111;
    for (int i = 0; i < 3; i++) fu_pkt[i] = mkPkt(40 + i, i, 32'hA0 + 32'(i), 1'b0);
    nextCycle();
    recovery_en = 1'b1;
    fu_valid    = 3'b111;
    #1;
    total++;
    if (cdb_en !== 1'b0 || cdb_grant !== 3'b000 || fu_ready !== 3'b000 || cdb_pkt !== '0) begin
      bad++;
      $display("[TB] FAIL recov_pulse got en=%0b gnt=%b rdy=%b pkt=%h want en=0 gnt=000 rdy=000 pkt=0",
               cdb_en, cdb_grant, fu_ready, cdb_pkt);
    end
    nextCycle();
    recovery_en = 1'b0;
    fu_valid    = '0;
    #1;
    total++;
    if (cdb_en !== 1'b0 || cdb_grant !== 3'b000 || fu_ready !== 3'b111) begin
      bad++;
      $display("[TB] FAIL recov_after got en=%0b gnt=%b rdy=%b want en=0 gnt=000 rdy=111",
               cdb_en, cdb_grant, fu_ready);
    end
    nextCycle();
    total++;
    if (cdb_en !== 1'b0) begin
      bad++;
      $display("[TB] FAIL recov_noaccept got en=%0b want en=0", cdb_en);
    end
  endtask

  task automatic test_async_reset;
    doReset();
    nextCycle();
    fu_valid = 3'b111;
    for (int i = 0; i < 3; i++) fu_pkt[i] = mkPkt(50 + i, i, 32'hB0 + 32'(i), 1'b0);
    nextCycle();
    fu_valid = '0;
    #1;
    total++;
    if (cdb_en !== 1'b1 || cdb_grant !== 3'b001) begin
      bad++;
      $display("[TB] FAIL areset_pre got en=%0b gnt=%b want en=1 gnt=001", cdb_en, cdb_grant);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (cdb_en !== 1'b0 || cdb_grant !== 3'b000 || fu_ready !== 3'b111 || cdb_pkt !== '0) begin
      bad++;
      $display("[TB] FAIL areset_now got en=%0b gnt=%b rdy=%b pkt=%h want en=0 gnt=000 rdy=111 pkt=0",
               cdb_en, cdb_grant, fu_ready, cdb_pkt);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      nextCycle();
      total++;
      if (cdb_en !== 1'b0) begin
        bad++;
        $display("[TB] FAIL areset_stale%0d got en=%0b pkt=%h want en=0", c, cdb_en, cdb_pkt);
      end
    end
  endtask

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_rotation();
    test_back_to_back();
    test_recovery();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
